// File: rtl/div_pkg.sv
// Shared types and sizing constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/divider_32_seq_if.sv
// Request (start/ready) and result (valid/ack) handshake bundle for divider_32_seq.
interface divider_32_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             valid;
  logic             ack;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, ack,
    input  ready, valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, ack,
    output ready, valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_trial_sub.sv
// One restoring-division trial: (WIDTH+1)-bit shifted remainder minus divisor.
module div_trial_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_sh_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             nonneg_o
);

  assign nonneg_o = (rem_sh_i >= {1'b0, divisor_i});
  // A non-negative result is below the divisor, so the low WIDTH bits are exact.
  assign diff_o   = rem_sh_i[WIDTH-1:0] - divisor_i;

endmodule

// File: rtl/divider_32_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define DIVIDER_32_SEQ_SIGNED_EN for two's-complement operands (truncation toward zero).
module divider_32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  divider_32_seq_if.slave bus
);

  localparam int               CNT_W    = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, q_q, q_d, dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial_diff, rem_next, q_next, dvd_mag, dvs_mag;
  logic             trial_nonneg;

`ifdef DIVIDER_32_SEQ_SIGNED_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  assign dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
  assign dvd_mag = bus.dividend;
  assign dvs_mag = bus.divisor;
`endif

  // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  assign rem_sh   = {rem_q, q_q[WIDTH-1]};
  assign rem_next = trial_nonneg ? trial_diff : rem_sh[WIDTH-1:0];
  assign q_next   = {q_q[WIDTH-2:0], trial_nonneg};

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .rem_sh_i (rem_sh),
    .divisor_i(dvsr_q),
    .diff_o   (trial_diff),
    .nonneg_o (trial_nonneg)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
`ifdef DIVIDER_32_SEQ_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cnt_d = '0;
          dbz_d = (bus.divisor == '0);
          if (bus.divisor == '0) begin
            q_d     = '1;
            rem_d   = bus.dividend;
            state_d = DONE;
          end else begin
            q_d     = dvd_mag;
            rem_d   = '0;
            dvsr_d  = dvs_mag;
            state_d = BUSY;
`ifdef DIVIDER_32_SEQ_SIGNED_EN
            neg_q_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            neg_r_d = bus.dividend[WIDTH-1];
`endif
          end
        end
      end
      BUSY: begin
        rem_d = rem_next;
        q_d   = q_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
`ifdef DIVIDER_32_SEQ_SIGNED_EN
          q_d   = neg_q_q ? -q_next : q_next;
          rem_d = neg_r_q ? -rem_next : rem_next;
`endif
        end
      end
      DONE: begin
        if (bus.ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIVIDER_32_SEQ_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
`ifdef DIVIDER_32_SEQ_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.valid       = (state_q == DONE);
  assign bus.quotient    = q_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_32_seq.sv
// Directed plus random stimulus for divider_32_seq against an arithmetic reference model.
module tb_divider_32_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  divider_32_seq_if #(.WIDTH(W)) dif ();

  divider_32_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Division as defined by the datapath: all-ones quotient and unchanged dividend for /0.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
`ifdef DIVIDER_32_SEQ_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dif.dividend = a;
    dif.divisor  = b;
    dif.start    = 1'b1;
    step();
    dif.start    = 1'b0;
  endtask

  // Returns cycles from the accepting edge until valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!dif.valid && lat < W + 20) begin
      step();
      lat++;
    end
  endtask

  task automatic div_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    logic [W-1:0] eq, er;
    ref_div(a, b, eq, er);
    issue(a, b);
    wait_valid(lat);
    check({tag, "_lat"}, lat, (b == '0) ? 1 : W + 1);
    check({tag, "_q"}, dif.quotient, eq);
    check({tag, "_r"}, dif.remainder, er);
    check({tag, "_dbz"}, dif.div_by_zero, (b == '0));
    dif.ack = 1'b1;
    step();
    dif.ack = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    dif.start    = 1'b0;
    dif.ack      = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;

    #12;
    check("rst_ready", dif.ready, 1);
    check("rst_valid", dif.valid, 0);
    check("rst_q", dif.quotient, 0);
    check("rst_r", dif.remainder, 0);
    check("rst_dbz", dif.div_by_zero, 0);
    step();
    rst_n = 1'b1;
    step();

    // ack held high throughout, including while not valid
    dif.ack = 1'b1;
    issue(100, 7);
    wait_valid(lat);
    check("d100_7_lat", lat, 33);
    check("d100_7_q", dif.quotient, 14);
    check("d100_7_r", dif.remainder, 2);
    check("d100_7_dbz", dif.div_by_zero, 0);
    step();
    dif.ack = 1'b0;
    check("d100_7_ready_after_ack", dif.ready, 1);

    div_check("max_by_1", 32'hFFFF_FFFF, 1);
    div_check("lt_5_9", 5, 9);
    div_check("eq_self", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    div_check("dbz_1234", 1234, 0);

    // div_by_zero drops once the next request is accepted
    issue(9, 3);
    check("dbz_clear", dif.div_by_zero, 0);
    wait_valid(lat);
    check("d9_3_q", dif.quotient, 3);
    dif.ack = 1'b1;
    step();
    dif.ack = 1'b0;

    // start during BUSY is ignored; result held while ack is withheld
    issue(1000, 3);
    repeat (5) step();
    dif.dividend = 77;
    dif.divisor  = 2;
    dif.start    = 1'b1;
    step();
    dif.start    = 1'b0;
    wait_valid(lat);
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", dif.valid, 1);
      check("hold_q", dif.quotient, 333);
      check("hold_r", dif.remainder, 1);
      step();
    end
    dif.ack = 1'b1;
    step();
    dif.ack = 1'b0;
    check("post_ack_ready", dif.ready, 1);
    check("post_ack_valid", dif.valid, 0);
    check("post_ack_q_kept", dif.quotient, 333);
    check("post_ack_r_kept", dif.remainder, 1);

    // start and ack together in DONE: only the ack is honoured
    issue(20, 4);
    wait_valid(lat);
    dif.ack      = 1'b1;
    dif.start    = 1'b1;
    dif.dividend = 9;
    dif.divisor  = 3;
    step();
    dif.ack   = 1'b0;
    dif.start = 1'b0;
    check("sa_ready", dif.ready, 1);
    check("sa_valid", dif.valid, 0);
    check("sa_q", dif.quotient, 5);
    step();
    check("sa_still_idle", dif.ready, 1);

    // asynchronous reset in the middle of BUSY
    issue(32'h1234_5678, 3);
    repeat (14) step();
    check("mid_busy_ready", dif.ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", dif.ready, 1);
    check("arst_valid", dif.valid, 0);
    check("arst_q", dif.quotient, 0);
    check("arst_r", dif.remainder, 0);
    step();
    rst_n = 1'b1;
    step();
    div_check("d50_5", 50, 5);

`ifdef DIVIDER_32_SEQ_SIGNED_EN
    div_check("s_m7_2", 32'hFFFF_FFF9, 2);
    check("s_m7_2_qval", dif.quotient, 32'hFFFF_FFFD);
    check("s_m7_2_rval", dif.remainder, 32'hFFFF_FFFF);
    div_check("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF);
    div_check("s_dbz", 32'hFFFF_FF00, 0);
`endif

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = $urandom_range(15, 1);
      if (i % 8 == 6) rb = '0;
      if (i % 8 == 3) rb = ra >> $urandom_range(20, 0);
      div_check("rand", ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
